// File: rtl/stream_handshake_monitor.sv
// stream_handshake_monitor
// Passive checker for one valid/ready stream. Counts completed transfers and
// back-pressure stall cycles, and flags source-side protocol violations:
// valid dropped before acceptance, payload changed while pending, and an
// optional stall timeout. All outputs are registered; nothing is driven back
// onto the monitored interface.
module stream_handshake_monitor #(
    parameter type         data_t        = logic,
    parameter int unsigned STALL_TIMEOUT = 0,
    parameter bit          FATAL         = 1'b0,
    // Enables the simulation messages raised on each detected error.
    parameter bit          REPORT_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic        ready_i,
    input  data_t       data_i,
    output logic [31:0] xfer_cnt_o,
    output logic [31:0] stall_cnt_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        pending_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_VALID_DROP  = 2'd1;
    localparam logic [1:0] ERR_DATA_CHANGE = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

    // Wait-counter value at which a pending beat is declared timed out.
    // Computed in 33 bits so the largest timeout setting cannot wrap.
    localparam logic [32:0] TIMEOUT_AT = 33'(STALL_TIMEOUT) + 33'd1;

    state_t      state_q, state_d;
    data_t       cap_q, cap_d;
    logic [31:0] xfer_q, xfer_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        tout_seen_q, tout_seen_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic        evt_drop;
    logic        evt_chg;
    logic        evt_tout;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Next-state, counter and error-recording logic for one sampled cycle.
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        xfer_d      = xfer_q;
        stall_d     = stall_q;
        wait_cnt_d  = wait_cnt_q;
        tout_seen_d = tout_seen_q;
        err_d       = err_q;
        code_d      = code_q;
        evt_drop    = 1'b0;
        evt_chg     = 1'b0;
        evt_tout    = 1'b0;

        if (clear_i) begin
            // Clear wins over anything sampled in the same cycle.
            state_d     = S_IDLE;
            cap_d       = '0;
            xfer_d      = '0;
            stall_d     = '0;
            wait_cnt_d  = '0;
            tout_seen_d = 1'b0;
            err_d       = 1'b0;
            code_d      = ERR_NONE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        if (ready_i) begin
                            xfer_d = sat_inc(xfer_q);
                        end else begin
                            cap_d       = data_i;
                            stall_d     = sat_inc(stall_q);
                            wait_cnt_d  = 32'd1;
                            tout_seen_d = 1'b0;
                            state_d     = S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (!valid_i) begin
                        evt_drop = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        // Case inequality so X/Z appearing on the payload is caught.
                        if (data_i !== cap_q) begin
                            evt_chg = 1'b1;
                        end
                        if (ready_i) begin
                            xfer_d  = sat_inc(xfer_q);
                            state_d = S_IDLE;
                        end else begin
                            stall_d    = sat_inc(stall_q);
                            wait_cnt_d = sat_inc(wait_cnt_q);
                            // The seen flag keeps a saturated wait counter from
                            // re-raising the timeout on every further cycle.
                            if ((STALL_TIMEOUT > 0) && !tout_seen_q &&
                                ({1'b0, wait_cnt_d} >= TIMEOUT_AT)) begin
                                evt_tout    = 1'b1;
                                tout_seen_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Only the first error is recorded; payload change outranks a
            // same-cycle timeout.
            if (!err_q) begin
                if (evt_chg) begin
                    err_d  = 1'b1;
                    code_d = ERR_DATA_CHANGE;
                end else if (evt_tout) begin
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                end else if (evt_drop) begin
                    err_d  = 1'b1;
                    code_d = ERR_VALID_DROP;
                end
            end
        end
    end

    // State registers; reset abandons any pending beat without flagging it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            xfer_q      <= '0;
            stall_q     <= '0;
            wait_cnt_q  <= '0;
            tout_seen_q <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            xfer_q      <= xfer_d;
            stall_q     <= stall_d;
            wait_cnt_q  <= wait_cnt_d;
            tout_seen_q <= tout_seen_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign xfer_cnt_o  = xfer_q;
    assign stall_cnt_o = stall_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign pending_o   = (state_q == S_PEND);

    // Simulation messages: the first error may be fatal, later ones only report.
    generate
        if (REPORT_EN) begin : g_report
            always @(posedge clk_i) begin
                if (rst_ni && (evt_drop || evt_chg || evt_tout)) begin
                    if (FATAL && !err_q) begin
                        $fatal(1, "%m: stream protocol error drop=%0b change=%0b timeout=%0b",
                               evt_drop, evt_chg, evt_tout);
                    end else begin
                        $error("%m: stream protocol error drop=%0b change=%0b timeout=%0b",
                               evt_drop, evt_chg, evt_tout);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_handshake_monitor.sv
// Self-checking bench for stream_handshake_monitor: directed scenarios with
// constant expectations, plus a randomized run compared against a
// transaction-level model of the monitored stream.
module tb_stream_handshake_monitor;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [31:0] xfer_cnt;
    logic [31:0] stall_cnt;
    logic        err;
    logic [1:0]  err_code;
    logic        pending;

    int total = 0;
    int bad   = 0;

    // Model of the stream: counts, first error, and the beat currently waiting.
    int unsigned m_xfer;
    int unsigned m_stall;
    int          m_code;
    bit          m_busy;
    logic [7:0]  m_data;
    int unsigned m_stalls_this_beat;

    stream_handshake_monitor #(
        .data_t        (logic [7:0]),
        .STALL_TIMEOUT (T),
        .FATAL         (1'b0),
        .REPORT_EN     (1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .valid_i     (valid),
        .ready_i     (ready),
        .data_i      (data),
        .xfer_cnt_o  (xfer_cnt),
        .stall_cnt_o (stall_cnt),
        .err_o       (err),
        .err_code_o  (err_code),
        .pending_o   (pending)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_xfer = 0;
        m_stall = 0;
        m_code = 0;
        m_busy = 1'b0;
        m_data = 8'h00;
        m_stalls_this_beat = 0;
    endfunction

    function automatic void m_note(int code);
        if (m_code == 0) m_code = code;
    endfunction

    // One sampled clock cycle of the interface, judged by the protocol rules.
    function automatic void m_sample(bit c, bit v, bit r, logic [7:0] d);
        if (c) begin
            m_reset();
        end else if (m_busy) begin
            if (!v) begin
                m_note(1);
                m_busy = 1'b0;
            end else begin
                if (d !== m_data) m_note(2);
                if (r) begin
                    m_xfer++;
                    m_busy = 1'b0;
                end else begin
                    m_stall++;
                    m_stalls_this_beat++;
                    if (m_stalls_this_beat == T + 1) m_note(3);
                end
            end
        end else if (v) begin
            if (r) begin
                m_xfer++;
            end else begin
                m_busy = 1'b1;
                m_data = d;
                m_stalls_this_beat = 1;
                m_stall++;
            end
        end
    endfunction

    // Drive one cycle from a falling edge; return at the next falling edge.
    task automatic step(input bit v, input bit r, input logic [7:0] d, input bit c);
        valid = v;
        ready = r;
        data  = d;
        clear = c;
        @(posedge clk);
        if (rst_n) m_sample(c, v, r, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (xfer_cnt !== 32'd0)  begin bad++; $display("FAIL reset_xfer got=%0d want=0", xfer_cnt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
        total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        total++; if (err_code !== 2'd0)   begin bad++; $display("FAIL reset_code got=%0d want=0", err_code); end
        total++; if (pending !== 1'b0)    begin bad++; $display("FAIL reset_pending got=%0b want=0", pending); end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 8'(i), 0);
        step(0, 0, 8'h00, 0);
        total++; if (xfer_cnt !== 32'd10) begin bad++; $display("FAIL b2b_xfer got=%0d want=10", xfer_cnt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stall_cnt); end
        total++; if (err !== 1'b0)        begin bad++; $display("FAIL b2b_err got=%0b want=0", err); end
        $display("test_back_to_back done");
    endtask

    task automatic test_stall();
        int pend_cycles;
        pend_cycles = 0;
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'hA5, 0);
            if (pending === 1'b1) pend_cycles++;
        end
        step(1, 1, 8'hA5, 0);
        if (pending === 1'b1) pend_cycles++;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 8'h00, 0);
            if (pending === 1'b1) pend_cycles++;
        end
        total++; if (xfer_cnt !== 32'd1)  begin bad++; $display("FAIL stall_xfer got=%0d want=1", xfer_cnt); end
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_stall got=%0d want=3", stall_cnt); end
        total++; if (pend_cycles != 3)    begin bad++; $display("FAIL stall_pending_cycles got=%0d want=3", pend_cycles); end
        total++; if (err !== 1'b0)        begin bad++; $display("FAIL stall_err got=%0b want=0", err); end
        $display("test_stall done");
    endtask

    task automatic test_data_change();
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL chg_err got=%0b want=1", err); end
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL chg_code got=%0d want=2", err_code); end
        step(0, 0, 8'h00, 0);
        total++; if (err_code !== 2'd2) begin bad++; $display("FAIL chg_code_kept got=%0d want=2", err_code); end
        total++; if (pending !== 1'b0)  begin bad++; $display("FAIL chg_pending got=%0b want=0", pending); end
        $display("test_data_change done");
    endtask

    task automatic test_valid_drop();
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h3C, 0);
        step(1, 0, 8'h3C, 0);
        step(0, 0, 8'h3C, 0);
        total++; if (err_code !== 2'd1) begin bad++; $display("FAIL drop_code got=%0d want=1", err_code); end
        total++; if (err !== 1'b1)      begin bad++; $display("FAIL drop_err got=%0b want=1", err); end
        total++; if (pending !== 1'b0)  begin bad++; $display("FAIL drop_pending got=%0b want=0", pending); end
        total++; if (xfer_cnt !== 32'd0) begin bad++; $display("FAIL drop_xfer got=%0d want=0", xfer_cnt); end
        $display("test_valid_drop done");
    endtask

    task automatic test_timeout();
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h77, 0);
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL tout_early_err got=%0b want=0", err); end
        step(1, 0, 8'h77, 0);
        total++; if (err_code !== 2'd3) begin bad++; $display("FAIL tout_code got=%0d want=3", err_code); end
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL tout_stall got=%0d want=5", stall_cnt); end
        total++; if (pending !== 1'b1)  begin bad++; $display("FAIL tout_pending got=%0b want=1", pending); end
        step(1, 1, 8'h77, 0);
        total++; if (xfer_cnt !== 32'd1) begin bad++; $display("FAIL tout_xfer got=%0d want=1", xfer_cnt); end
        total++; if (err_code !== 2'd3) begin bad++; $display("FAIL tout_code_kept got=%0d want=3", err_code); end
        $display("test_timeout done");
    endtask

    task automatic test_clear();
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        step(1, 1, 8'h02, 0);
        total++; if (xfer_cnt !== 32'd2) begin bad++; $display("FAIL clr_pre_xfer got=%0d want=2", xfer_cnt); end
        step(1, 1, 8'h03, 1);
        total++; if (xfer_cnt !== 32'd0)  begin bad++; $display("FAIL clr_xfer got=%0d want=0", xfer_cnt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL clr_stall got=%0d want=0", stall_cnt); end
        step(1, 1, 8'h04, 0);
        total++; if (xfer_cnt !== 32'd1) begin bad++; $display("FAIL clr_resume_xfer got=%0d want=1", xfer_cnt); end
        $display("test_clear done");
    endtask

    task automatic test_reset_mid_beat();
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h10, 0);
        step(1, 0, 8'h5A, 0);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL rmid_pending_before got=%0b want=1", pending); end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        total++; if (xfer_cnt !== 32'd0)  begin bad++; $display("FAIL rmid_xfer got=%0d want=0", xfer_cnt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rmid_stall got=%0d want=0", stall_cnt); end
        total++; if (pending !== 1'b0)    begin bad++; $display("FAIL rmid_pending got=%0b want=0", pending); end
        total++; if (err !== 1'b0)        begin bad++; $display("FAIL rmid_err got=%0b want=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 8'h00, 0);
        total++; if (err !== 1'b0)      begin bad++; $display("FAIL rmid_err_after got=%0b want=0", err); end
        total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rmid_code_after got=%0d want=0", err_code); end
        $display("test_reset_mid_beat done");
    endtask

    task automatic test_random();
        bit         v, r, c;
        logic [7:0] d;
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 4) != 0);
            r = ($urandom_range(0, 1) == 1);
            if (m_busy && ($urandom_range(0, 9) != 0)) d = m_data;
            else d = 8'($urandom_range(0, 255));
            step(v, r, d, c);
            total++; if (xfer_cnt !== m_xfer)   begin bad++; $display("FAIL rnd_xfer cyc=%0d got=%0d want=%0d", i, xfer_cnt, m_xfer); end
            total++; if (stall_cnt !== m_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", i, stall_cnt, m_stall); end
            total++; if (err !== (m_code != 0)) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0b", i, err, (m_code != 0)); end
            total++; if (err_code !== 2'(m_code)) begin bad++; $display("FAIL rnd_code cyc=%0d got=%0d want=%0d", i, err_code, m_code); end
            total++; if (pending !== m_busy)    begin bad++; $display("FAIL rnd_pending cyc=%0d got=%0b want=%0b", i, pending, m_busy); end
        end
        $display("test_random done: xfer=%0d stall=%0d", m_xfer, m_stall);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_stall();
        test_data_change();
        test_valid_drop();
        test_timeout();
        test_clear();
        test_reset_mid_beat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_handshake_monitor.md
# stream_handshake_monitor

Passive, cycle-accurate checker for one valid/ready stream interface. It samples the handshake on every rising clock edge. It counts transfers and back-pressure stall cycles, and flags protocol violations by the upstream source: valid retracted or data changed before acceptance, or a stall that exceeds a timeout. It sits downstream of the randomizing ready driver and consumes its output as `ready_i`, so every testbench that applies random back-pressure gets protocol checking and throughput statistics.

## Interface
- `data_t`, default `logic`: payload type being monitored.
- `STALL_TIMEOUT`, default `0`: maximum consecutive stall cycles allowed; `0` disables the timeout check.
- `FATAL`, default `1'b0`: when 1, the first error also calls `$fatal`; when 0, it calls `$error` only.

Ports:
- `clk_i`  in  1  clock; all sampling on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear of counters, errors and FSM.
- `valid_i`  in  1  source valid.
- `ready_i`  in  1  sink ready (from the random ready driver).
- `data_i`  in  `$bits(data_t)`  payload.
- `xfer_cnt_o`  out  32  completed handshakes; saturating.
- `stall_cnt_o`  out  32  cycles with `valid_i && !ready_i`; saturating.
- `err_o`  out  1  sticky error flag.
- `err_code_o`  out  2  first error: 0 none, 1 VALID_DROP, 2 DATA_CHANGE, 3 TIMEOUT.
- `pending_o`  out  1  high while the FSM is in PEND.

## Operation
FSM states are IDLE and PEND. A captured-data register holds the data of the pending beat.

IDLE:
- `valid_i && ready_i`: transfer; `xfer_cnt_o` +1; stay in IDLE.
- `valid_i && !ready_i`: capture `data_i`; stall +1; wait counter := 1; go to PEND.

PEND:
- `!valid_i`: raise VALID_DROP; go to IDLE.
- `valid_i && data_i != captured` (compared with `!==`, so X/Z changes count): raise DATA_CHANGE. The handshake, if `ready_i`, is still counted.
- `valid_i && ready_i`: `xfer_cnt_o` +1; go to IDLE. Both conditions can hold in the same cycle; DATA_CHANGE takes precedence for `err_code_o`.
- `valid_i && !ready_i`: stall +1; wait +1.

Timeout:
- Checked when `STALL_TIMEOUT > 0`.
- Raised when the wait counter reaches `STALL_TIMEOUT + 1` while still in PEND without ready.
- Raised once per pending beat; the FSM stays in PEND.

Error recording:
- `err_o` is set on the first error and stays set until `clear_i` or reset.
- `err_code_o` records only the first error.
- Later errors still emit `$error` messages but never overwrite the code.

Counters:
- 32-bit, saturate at `32'hFFFF_FFFF`; never wrap.
- The wait counter is 32-bit and also saturates.

`clear_i` behaviour:
- All counters and error state go to 0; FSM goes to IDLE.
- `clear_i` takes priority over any same-cycle event, so that cycle's handshake is not counted.
- Sampling resumes on the next edge.

Reset, including mid-beat: all state clears immediately and asynchronously, and no error is raised for the abandoned beat.

## Timing
- Reset values: `xfer_cnt_o = 0`, `stall_cnt_o = 0`, `err_o = 0`, `err_code_o = 0`, `pending_o = 0`. The captured-data register is `'0`.
- Outputs are registered, and an event sampled at edge N is visible after edge N.
- Handshakes issued in back-to-back cycles are each counted; throughput is 1 per cycle.
- A stall of k cycles followed by acceptance adds k to `stall_cnt_o` and 1 to `xfer_cnt_o`.
- With `STALL_TIMEOUT = T`, TIMEOUT is flagged at the edge sampling the (T+1)-th consecutive stall cycle.
- Purely passive: no combinational path from any input to any output.

## Test plan
- **Reset then 10 back-to-back beats** with `valid = ready = 1` → `xfer_cnt_o = 10`, `stall_cnt_o = 0`, `err_o = 0`.
- **Single beat with `ready_i` low for 3 cycles**, data constant `8'hA5`, then ready → `xfer_cnt_o = 1`, `stall_cnt_o = 3`, `pending_o` high exactly 3 cycles.
- **Data changed during a stall:** valid with data `8'h11`, ready low; change data to `8'h22` the next cycle → `err_o = 1`, `err_code_o = 2`. A later valid drop leaves the code at 2.
- **Valid retracted mid-stall:** valid high, ready low for 2 cycles, then valid low → `err_code_o = 1`, FSM in IDLE, `xfer_cnt_o` unchanged.
- **Timeout:** `STALL_TIMEOUT = 4`, ready held low for 5 cycles → `err_code_o = 3` after the 5th sampling edge, `stall_cnt_o = 5`. Then ready high → `xfer_cnt_o = 1`.
- **Clear and reset mid-beat:** `clear_i` on the same cycle as a handshake → counters 0 and that beat is not counted. Assert `rst_ni` low during PEND → all outputs 0 immediately, no error raised.
